// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sequencer: opcodes, FSM encoding
// and the default datapath width.
package alu_share_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] OP_AND = 6'd36;
  localparam logic [5:0] OP_OR  = 6'd37;
  localparam logic [5:0] OP_ADD = 6'd32;
  localparam logic [5:0] OP_SUB = 6'd34;
  localparam logic [5:0] OP_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer value to use
// after this grant (points at the loser so it wins the next tie).
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
    ptr_nxt = ptr;
    if (gnt[0])      ptr_nxt = 1'b1;
    else if (gnt[1]) ptr_nxt = 1'b0;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two valid/ready requesters:
// IDLE arbitrates and latches, EXEC drives the ALU and captures, RESP holds the result.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_result
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             own_q, own_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [5:0]       alu_sig_q, alu_sig_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [1:0] gnt;
  logic       ptr_nxt;
  logic       arb_en;
  logic [5:0] op_sel;

  // Grants only in IDLE, and never while reset is held so ready reads 0 in reset.
  assign arb_en = (state_q == ST_IDLE) && reset;

  rr_arbiter_2 u_arb (
    .req     ({req1_valid, req0_valid}),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    ill_d     = ill_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sig_d = alu_sig_q;
    res_d     = res_q;
    err_d     = err_q;
    op_sel    = gnt[1] ? req1_op : req0_op;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          ptr_d     = ptr_nxt;
          own_d     = gnt[1];
          alu_a_d   = gnt[1] ? req1_a : req0_a;
          alu_b_d   = gnt[1] ? req1_b : req0_b;
          ill_d     = !op_legal(op_sel);
          // Illegal codes never reach the ALU.
          alu_sig_d = op_legal(op_sel) ? op_sel : 6'd0;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = ill_q ? '0 : alu_result;
        err_d   = ill_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (own_q ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= FIRST_PRIO;
      own_q     <= 1'b0;
      ill_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sig_q <= 6'd0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      ill_q     <= ill_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sig_q <= alu_sig_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_signal = alu_sig_q;
  assign rsp0_valid = (state_q == ST_RESP) && !own_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  own_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench: accepted operations push expected results computed from the
// opcode rules; a negedge monitor checks grants, ALU drive, latency and responses.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int W  = 32;
  localparam bit FP = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic         rv[2];
  logic [5:0]   rop[2];
  logic [W-1:0] ra[2];
  logic [W-1:0] rb[2];
  logic         rr[2];
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [W-1:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result, alu_diff;
  logic [5:0] alu_signal;

  int checks = 0, failures = 0, cyc = 0;
  int hold_lo[2];
  bit rnd_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_ctrl #(.WIDTH(W), .FIRST_PRIO(FP)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal), .alu_result(alu_result)
  );

  // Parent-level ALU; unknown codes give a poison value that must never be returned.
  assign alu_diff = alu_a - alu_b;
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_signal)
      6'd36: alu_result = alu_a & alu_b;
      6'd37: alu_result = alu_a | alu_b;
      6'd32: alu_result = alu_a + alu_b;
      6'd34: alu_result = alu_diff;
      6'd42: alu_result = {31'd0, alu_diff[31]};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event cyc=%0d", nm, cyc);
  endtask

  // Reference: what the requester should get back for an operation.
  task automatic model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic e, output logic [5:0] sig);
    logic [W-1:0] d;
    d = a - b;
    e = 1'b0;
    sig = op;
    case (op)
      6'd36: r = a & b;
      6'd37: r = a | b;
      6'd32: r = a + b;
      6'd34: r = d;
      6'd42: r = (d >> 31);
      default: begin r = '0; e = 1'b1; sig = 6'd0; end
    endcase
  endtask

  typedef struct {
    int           k;
    logic [W-1:0] data;
    logic         err;
    logic [5:0]   sig;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur, nw;
  bit   inflight = 1'b0, tptr = FP, head_seen = 1'b0;
  int   exec_cyc = -1, mk;
  logic [1:0] vv, gnt_act, exp_rdy, rsp_v;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      inflight  = 1'b0;
      tptr      = FP;
      head_seen = 1'b0;
      exec_cyc  = -1;
    end else begin
      vv      = {rv[1], rv[0]};
      gnt_act = {req1_ready, req0_ready};
      rsp_v   = {rsp1_valid, rsp0_valid};
      if (inflight)         exp_rdy = 2'b00;
      else if (vv == 2'b11) exp_rdy = tptr ? 2'b10 : 2'b01;
      else                  exp_rdy = vv;
      chk("req_ready", W'(gnt_act), W'(exp_rdy));
      if (cyc == exec_cyc && exp_q.size() > 0) begin
        chk("exec_alu_signal", W'(alu_signal), W'(exp_q[0].sig));
        chk("exec_alu_a", alu_a, exp_q[0].a);
        chk("exec_alu_b", alu_b, exp_q[0].b);
      end
      if (rsp_v != 2'b00) begin
        if (exp_q.size() == 0) chk("rsp_spurious", W'(rsp_v), W'(2'b00));
        else begin
          cur = exp_q[0];
          chk("rsp_owner", W'(rsp_v), cur.k ? W'(2'b10) : W'(2'b01));
          chk("rsp_data", cur.k ? rsp1_data : rsp0_data, cur.data);
          chk("rsp_err", W'(cur.k ? rsp1_err : rsp0_err), W'(cur.err));
          if (!head_seen) chk("rsp_latency", W'(cyc - cur.acc), W'(2));
          head_seen = 1'b1;
          if (cur.k ? rr[1] : rr[0]) begin
            void'(exp_q.pop_front());
            inflight  = 1'b0;
            head_seen = 1'b0;
          end
        end
      end else if (exp_q.size() > 0 && !head_seen && (cyc - exp_q[0].acc) >= 2) begin
        chk("rsp_missing", W'(rsp_v), exp_q[0].k ? W'(2'b10) : W'(2'b01));
        head_seen = 1'b1;
      end
      if ((gnt_act & vv) != 2'b00) begin
        mk = gnt_act[1] ? 1 : 0;
        nw.k = mk;
        nw.a = ra[mk];
        nw.b = rb[mk];
        nw.acc = cyc;
        model(rop[mk], ra[mk], rb[mk], nw.data, nw.err, nw.sig);
        exp_q.push_back(nw);
        tptr     = (mk == 0);
        inflight = 1'b1;
        exec_cyc = cyc + 1;
      end
    end
  end

  initial begin
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (hold_lo[k] > 0) begin
          rr[k] = 1'b0;
          hold_lo[k]--;
        end else rr[k] = rnd_mode ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic drive(input int k, input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    rv[k] = 1'b1; rop[k] = op; ra[k] = a; rb[k] = b;
    @(negedge clk);
    while (!(k == 1 ? req1_ready : req0_ready) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) fail_now("drive_timeout");
    @(posedge clk);
    #1;
    rv[k] = 1'b0; rop[k] = 6'($urandom); ra[k] = $urandom; rb[k] = $urandom;
  endtask

  function automatic logic [5:0] rnd_op();
    logic [5:0] legal [5];
    legal = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    if ($urandom_range(9) < 8) return legal[$urandom_range(4)];
    return 6'($urandom);
  endfunction

  task automatic rand_stream(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      drive(k, rnd_op(), $urandom, ($urandom_range(3) == 0) ? W'($urandom_range(15)) : $urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, W'({req1_ready, req0_ready}), W'(2'b00));
    chk({tag, "_rsp_valid"}, W'({rsp1_valid, rsp0_valid}), W'(2'b00));
    chk({tag, "_rsp0_data"}, rsp0_data, '0);
    chk({tag, "_rsp1_data"}, rsp1_data, '0);
    chk({tag, "_rsp_err"}, W'({rsp1_err, rsp0_err}), W'(2'b00));
    chk({tag, "_alu_a"}, alu_a, '0);
    chk({tag, "_alu_b"}, alu_b, '0);
    chk({tag, "_alu_signal"}, W'(alu_signal), '0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || inflight) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) fail_now(nm);
    #1;
  endtask

  initial begin
    #200000;
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    hold_lo[0] = 0;
    hold_lo[1] = 0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rop[k] = '0; ra[k] = '0; rb[k] = '0;
    end
    rv[0] = 1'b1;
    #12;
    chk_reset_outputs("reset");
    rv[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // contention: req0 first, then req1, repeated
    for (int p = 0; p < 2; p++) begin
      fork
        drive(0, OP_SUB, 32'd10, 32'd3);
        drive(1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
      join
    end
    drain("drain_contention");

    drive(0, OP_ADD, 32'd5, 32'd7);
    drain("drain_add");

    drive(0, OP_SLT, 32'd5, 32'd7);
    drive(1, OP_SLT, 32'd7, 32'd5);
    drive(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    drive(1, OP_AND, 32'hFFFF_0000, 32'h1234_5678);
    drive(0, OP_SLT, 32'h8000_0000, 32'd1);
    drain("drain_slt_and");

    drive(0, 6'h3F, 32'd1, 32'd2);
    drain("drain_illegal");

    // backpressure on requester 1 with requester 0 waiting
    @(posedge clk); #1;
    hold_lo[1] = 14;
    fork
      drive(1, OP_ADD, 32'd100, 32'd23);
      begin
        repeat (2) begin @(posedge clk); #1; end
        drive(0, OP_OR, 32'h0000_1100, 32'h0000_0011);
      end
    join
    drain("drain_backpressure");

    rnd_mode = 1'b1;
    @(posedge clk); #1;
    fork
      rand_stream(0, 40);
      rand_stream(1, 40);
    join
    drain("drain_random");
    rnd_mode = 1'b0;

    // reset during EXEC after a requester-0 win moved the pointer to 1
    @(posedge clk); #1;
    drive(0, OP_ADD, 32'h0000_ABCD, 32'h0000_0001);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) begin @(posedge clk); #1; end
    chk_reset_outputs("held_reset");
    reset = 1'b1;
    fork
      drive(0, OP_ADD, 32'd1, 32'd1);
      drive(1, OP_SUB, 32'd9, 32'd4);
    join
    drain("drain_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
